// File: rtl/sm_uart_tx.sv
// Byte-wide UART transmitter with valid/ready input, 8N1 line format
// (8E1 when SM_UART_TX_PARITY_EN is defined). All outputs registered.
module sm_uart_tx #(
    parameter int unsigned CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       done
);

    localparam int unsigned CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CLK_PER_BIT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SM_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_d, ready_d, done_d;
    logic            baud_end;
`ifdef SM_UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    // State and registered outputs; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx       <= 1'b1;
            ready    <= 1'b1;
            done     <= 1'b0;
`ifdef SM_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx       <= tx_d;
            ready    <= ready_d;
            done     <= done_d;
`ifdef SM_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next state; tx_d is the value for the coming cycle, so each bit is
    // loaded at the terminal count of the previous one.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx;
        ready_d  = ready;
        done_d   = 1'b0;
`ifdef SM_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (valid && ready) begin
                    shift_d  = data;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    ready_d  = 1'b0;
`ifdef SM_UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef SM_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef SM_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                done_d = (baud_q == BAUD_PRE);
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sm_uart_tx.sv
// Directed self-checking bench for sm_uart_tx at CLK_PER_BIT = 4; define
// SM_UART_TX_PARITY_EN for both files to exercise the parity build.
module tb_sm_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef SM_UART_TX_PARITY_EN
    localparam int unsigned F = 11;
`else
    localparam int unsigned F = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       done;

    int checks = 0;
    int errors = 0;

    sm_uart_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for bit slot i of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef SM_UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Entered in cycle N+1 after a handshake; leaves in cycle N+1+F*CPB.
    task automatic check_frame(input string tag, input logic [7:0] b, input bit noise);
        for (int c = 1; c <= int'(F * CPB); c++) begin
            chk({tag, "_tx"}, 32'(tx), 32'(exp_bit(b, (c - 1) / int'(CPB))));
            chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
            chk({tag, "_done"}, 32'(done), 32'(c == int'(F * CPB)));
            if (noise) begin
                valid = (c < int'(F * CPB)) ? c[0] : 1'b0;
                data  = 8'hFF;
            end
            tick();
        end
        chk({tag, "_ready_end"}, 32'(ready), 32'd1);
        chk({tag, "_tx_end"}, 32'(tx), 32'd1);
        chk({tag, "_done_end"}, 32'(done), 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
        data  = b;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;

        // Reset held with valid high: line stays idle.
        valid = 1'b1;
        data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_done", 32'(done), 32'd0);
        end
        rst   = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_tx", 32'(tx), 32'd1);
            chk("post_rst_ready", 32'(ready), 32'd1);
        end

        // Single byte.
        send(8'hA5);
        check_frame("a5", 8'hA5, 1'b0);

        // Back-to-back with valid held; data changes while busy are ignored.
        data  = 8'h00;
        valid = 1'b1;
        tick();
        data  = 8'hFF;
        check_frame("b2b0", 8'h00, 1'b0);
        tick();
        valid = 1'b0;
        check_frame("b2b1", 8'hFF, 1'b0);

        // Noise on valid/data while busy.
        send(8'h3C);
        check_frame("noise", 8'h3C, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("noise_idle_tx", 32'(tx), 32'd1);
            chk("noise_idle_ready", 32'(ready), 32'd1);
        end

        // Reset during data bit 3 of 0xA5.
        send(8'hA5);
        for (int i = 0; i < 17; i++) tick();
        chk("mid_bit3_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("mid_after_done", 32'(done), 32'd0);
            chk("mid_after_tx", 32'(tx), 32'd1);
        end
        send(8'h81);
        check_frame("r81", 8'h81, 1'b0);

`ifdef SM_UART_TX_PARITY_EN
        send(8'h07);
        check_frame("par07", 8'h07, 1'b0);
        send(8'h03);
        check_frame("par03", 8'h03, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
